// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bus: redirect/hazard controls in, instruction memory port and IF/ID outputs.
interface fetch_ctrl_if;
    logic        stall;
    logic        flush;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [9:0]  im_addr;
    logic [31:0] im_instr;
    logic [31:0] pc;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic        id_valid;
    logic        addr_err;

    modport slave (
        input  stall, flush, br_taken, br_target, jump, jump_target, im_instr,
        output im_addr, pc, id_instr, id_pc4, id_valid, addr_err
    );

    modport master (
        output stall, flush, br_taken, br_target, jump, jump_target, im_instr,
        input  im_addr, pc, id_instr, id_pc4, id_valid, addr_err
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC sequencing with jump/branch redirect, IF/ID register,
// and a sticky illegal-address trap that freezes fetch until reset.
module fetch_ctrl #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] PC_LIMIT = 32'h0000_3FFC
) (
    input  logic        clk,
    input  logic        reset,
    fetch_ctrl_if.slave bus
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4;
    logic [31:0] cand;
    logic        cand_bad;
    logic        err_q, err_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic        id_valid_q, id_valid_d;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        cand = pc_plus4;
        if (bus.jump) begin
            cand = bus.jump_target;
        end else if (bus.br_taken) begin
            cand = bus.br_target;
        end
    end

    // pc+4 past PC_LIMIT is caught here as well, so fetch never wraps back to PC_RESET.
    assign cand_bad = (cand < PC_RESET) || (cand > PC_LIMIT) || (cand[1:0] != 2'b00);

    always_comb begin
        pc_d  = pc_q;
        err_d = err_q;
        if (!err_q && !bus.stall) begin
            if (cand_bad) begin
                err_d = 1'b1;
            end else begin
                pc_d = cand;
            end
        end
    end

    // The redirect-cycle fetch (delay slot) is captured normally; only flush squashes it.
    always_comb begin
        id_instr_d = id_instr_q;
        id_pc4_d   = id_pc4_q;
        id_valid_d = id_valid_q;
        if (bus.flush) begin
            id_instr_d = 32'd0;
            id_valid_d = 1'b0;
        end else if (bus.stall) begin
            id_instr_d = id_instr_q;
        end else if (err_q) begin
            id_instr_d = 32'd0;
            id_valid_d = 1'b0;
        end else begin
            id_instr_d = bus.im_instr;
            id_pc4_d   = pc_plus4;
            id_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= PC_RESET;
            err_q      <= 1'b0;
            id_instr_q <= 32'd0;
            id_pc4_q   <= 32'd0;
            id_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            err_q      <= err_d;
            id_instr_q <= id_instr_d;
            id_pc4_q   <= id_pc4_d;
            id_valid_q <= id_valid_d;
        end
    end

    assign bus.im_addr  = pc_q[11:2];
    assign bus.pc       = pc_q;
    assign bus.id_instr = id_instr_q;
    assign bus.id_pc4   = id_pc4_q;
    assign bus.id_valid = id_valid_q;
    assign bus.addr_err = err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: expected IF/ID contents are queued when a fetch is issued
// and compared when the decode register presents them.
module tb_fetch_ctrl;

    localparam int NEW    = 0;
    localparam int BUBBLE = 1;
    localparam int HOLD   = 2;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } sb_t;

    logic clk = 1'b0;
    logic reset;
    fetch_ctrl_if bus ();

    int n_checks = 0;
    int n_pass   = 0;

    sb_t         sb[$];
    logic [31:0] cur_pc;
    logic [31:0] last_instr;
    logic [31:0] last_pc4;
    logic        last_valid;

    fetch_ctrl #(
        .PC_RESET(32'h0000_3000),
        .PC_LIMIT(32'h0000_3FFC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memval(input logic [9:0] a);
        return 32'hC000_0000 ^ {a, 6'h15, a, 6'h2A};
    endfunction

    assign bus.im_instr = memval(bus.im_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic st, input logic fl, input logic j, input logic [31:0] jt,
                         input logic b, input logic [31:0] bt);
        bus.stall       = st;
        bus.flush       = fl;
        bus.jump        = j;
        bus.jump_target = jt;
        bus.br_taken    = b;
        bus.br_target   = bt;
    endtask

    task automatic tick(input string tag, input int mode, input logic [31:0] exp_pc,
                        input logic exp_err);
        sb_t e;
        chk({tag, ".im_addr"}, 32'(bus.im_addr), 32'(cur_pc[11:2]));
        if (mode == NEW) sb.push_back('{memval(cur_pc[11:2]), cur_pc + 32'd4});
        @(posedge clk);
        #1;
        chk({tag, ".pc"}, bus.pc, exp_pc);
        chk({tag, ".addr_err"}, 32'(bus.addr_err), 32'(exp_err));
        case (mode)
            NEW: begin
                chk({tag, ".id_valid"}, 32'(bus.id_valid), 32'd1);
                e = sb.pop_front();
                chk({tag, ".id_instr"}, bus.id_instr, e.instr);
                chk({tag, ".id_pc4"}, bus.id_pc4, e.pc4);
                last_instr = e.instr;
                last_pc4   = e.pc4;
                last_valid = 1'b1;
            end
            BUBBLE: begin
                chk({tag, ".id_valid"}, 32'(bus.id_valid), 32'd0);
                chk({tag, ".id_instr"}, bus.id_instr, 32'd0);
                chk({tag, ".id_pc4"}, bus.id_pc4, last_pc4);
                last_instr = 32'd0;
                last_valid = 1'b0;
            end
            default: begin
                chk({tag, ".id_valid"}, 32'(bus.id_valid), 32'(last_valid));
                chk({tag, ".id_instr"}, bus.id_instr, last_instr);
                chk({tag, ".id_pc4"}, bus.id_pc4, last_pc4);
            end
        endcase
        cur_pc = exp_pc;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, ".pc"}, bus.pc, 32'h0000_3000);
        chk({tag, ".im_addr"}, 32'(bus.im_addr), 32'd0);
        chk({tag, ".addr_err"}, 32'(bus.addr_err), 32'd0);
        chk({tag, ".id_valid"}, 32'(bus.id_valid), 32'd0);
        chk({tag, ".id_instr"}, bus.id_instr, 32'd0);
        chk({tag, ".id_pc4"}, bus.id_pc4, 32'd0);
        reset      = 1'b0;
        cur_pc     = 32'h0000_3000;
        last_instr = 32'd0;
        last_pc4   = 32'd0;
        last_valid = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        @(posedge clk);
        do_reset("rst");

        // Sequential fetch, then a two-cycle stall
        tick("seq0", NEW, 32'h3004, 1'b0);
        tick("seq1", NEW, 32'h3008, 1'b0);
        tick("seq2", NEW, 32'h300C, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        tick("stall0", HOLD, 32'h300C, 1'b0);
        tick("stall1", HOLD, 32'h300C, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        tick("unstall", NEW, 32'h3010, 1'b0);

        // Jump back to 0x3008, then jump and branch together
        drive(1'b0, 1'b0, 1'b1, 32'h3008, 1'b0, 32'd0);
        tick("jmp", NEW, 32'h3008, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 32'h3100, 1'b1, 32'h3200);
        tick("jmp_br", NEW, 32'h3100, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        tick("after_jmp", NEW, 32'h3104, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h3200);
        tick("br", NEW, 32'h3200, 1'b0);

        // Redirect held under stall is ignored until stall drops
        drive(1'b1, 1'b0, 1'b1, 32'h3300, 1'b0, 32'd0);
        tick("stall_jmp", HOLD, 32'h3200, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 32'h3300, 1'b0, 32'd0);
        tick("jmp_late", NEW, 32'h3300, 1'b0);

        // Flush beats stall in IF/ID, PC still holds
        drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        tick("flush_stall", BUBBLE, 32'h3300, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        tick("flush", BUBBLE, 32'h3304, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        tick("post_flush", NEW, 32'h3308, 1'b0);

        // Branch out of range: delay slot delivered, then trap
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h4000);
        tick("bad_br", NEW, 32'h3308, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        tick("err0", BUBBLE, 32'h3308, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        tick("err_flush", BUBBLE, 32'h3308, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 32'h3400, 1'b0, 32'd0);
        tick("err_jmp", BUBBLE, 32'h3308, 1'b1);

        // Reset overrides stall/redirect with the trap set
        drive(1'b1, 1'b0, 1'b1, 32'h3400, 1'b1, 32'h3500);
        do_reset("rst_err");

        // Misaligned and below-base targets
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h3002);
        tick("misalign", NEW, 32'h3000, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 32'h2FFC, 1'b0, 32'd0);
        do_reset("rst2");
        drive(1'b0, 1'b0, 1'b1, 32'h2FFC, 1'b0, 32'd0);
        tick("below", NEW, 32'h3000, 1'b1);
        do_reset("rst3");

        // Run up to PC_LIMIT without redirect
        drive(1'b0, 1'b0, 1'b1, 32'h3FF4, 1'b0, 32'd0);
        tick("to_top", NEW, 32'h3FF4, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        tick("top0", NEW, 32'h3FF8, 1'b0);
        tick("top1", NEW, 32'h3FFC, 1'b0);
        tick("limit", NEW, 32'h3FFC, 1'b1);
        tick("limit_after", BUBBLE, 32'h3FFC, 1'b1);

        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
